imem_responder: RTL and testbench

//  Instruction-memory responder: the memory end of the fetch interface. It

---
 rtl/rv_pkg.sv | 14 +
 rtl/imem_responder_if.sv | 37 +++
 rtl/imem_array.sv | 44 ++++
 rtl/imem_responder.sv | 112 +++++++++++
 tb/tb_imem_responder.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the fetch side of the core.
//   RV_NOP       : canonical RISC-V NOP (addi x0, x0, 0), returned on fetch errors
//   imem_state_t : state encoding of the instruction-memory responder FSM
package rv_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IMEM_IDLE = 2'd0,
    IMEM_WAIT = 2'd1,
    IMEM_RESP = 2'd2
  } imem_state_t;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch interface between the PC/fetch stage (master) and the instruction
// memory (slave), plus the backdoor load port used to fill memory.
//
// Handshake rule for both channels: a transfer happens in the cycle where
// valid && ready are both 1 at the rising clock edge. The sender holds its
// payload stable from raising valid until that transfer; ready may depend
// combinationally on state but never on valid.
//
//   req_valid/req_ready/req_addr              : request channel (master -> slave)
//   rsp_valid/rsp_ready/rsp_instr/rsp_err     : response channel (slave -> master)
//   ld_en/ld_addr/ld_data                     : backdoor word write (master -> slave)
interface imem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic        rsp_err;

  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  modport slave (
    input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_instr, rsp_err
  );

  modport master (
    output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_instr, rsp_err
  );

endinterface

// File: rtl/imem_array.sv
// Instruction storage: DEPTH_WORDS x 32 words, one synchronous read port and
// one write port.
//   clk, reset : clock; reset clears only the read data register
//   rd_en      : capture mem[rd_idx] into rd_data at the next edge
//   rd_idx     : word index for the read
//   rd_data    : registered read data, held while rd_en is low
//   wr_en      : write wr_data into mem[wr_idx] at the next edge
//   wr_idx     : word index for the write
//   wr_data    : write data
// A read and a write to the same word in one cycle return the old word.
module imem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data
);

  logic [31:0] mem [DEPTH_WORDS];

  // Storage itself is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Separate register so the output has a defined reset value; the
  // non-blocking read samples the word before any same-edge write lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= 32'h0;
    end else if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: memory end of the fetch interface. Accepts
// one fetch address at a time, waits LATENCY cycles and presents the 32-bit
// instruction (or a NOP with rsp_err set for misaligned / out-of-range
// addresses) until the consumer takes it.
//   clk       : clock
//   reset     : asynchronous, active-high reset
//   bus       : fetch interface, slave side (request, response, backdoor load)
//   state_dbg : current FSM state, for observation only
module imem_responder
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                clk,
  input  logic                reset,
  imem_responder_if.slave     bus,
  output imem_state_t         state_dbg
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  imem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q;

  logic          accept;
  logic          req_bad;
  logic [AW-1:0] req_idx;
  logic          ld_ok;
  logic [31:0]   rd_data;
  logic          unused_ld_bits;

  // Address decode. Any set bit above the array span is out of range: there
  // is no wrap-around onto low memory.
  assign req_idx = bus.req_addr[AW+1:2];
  assign req_bad = (bus.req_addr[1:0] != 2'b00) || (|bus.req_addr[31:AW+2]);
  assign accept  = bus.req_valid && (state_q == IMEM_IDLE);

  // Backdoor writes outside the array are dropped; low bits are ignored.
  assign ld_ok          = bus.ld_en && !(|bus.ld_addr[31:AW+2]);
  assign unused_ld_bits = ^bus.ld_addr[1:0];

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .rd_en   (accept && !req_bad),
    .rd_idx  (req_idx),
    .rd_data (rd_data),
    .wr_en   (ld_ok),
    .wr_idx  (bus.ld_addr[AW+1:2]),
    .wr_data (bus.ld_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IMEM_IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        err_q <= req_bad;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IMEM_IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = IMEM_RESP;
          end else begin
            state_d = IMEM_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      IMEM_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = IMEM_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      IMEM_RESP: begin
        if (bus.rsp_ready) begin
          state_d = IMEM_IDLE;
        end
      end
      default: begin
        state_d = IMEM_IDLE;
      end
    endcase
  end

  // Outputs derive from registered state only, so they stay stable for the
  // whole RESP phase and rsp_valid drops as soon as reset asserts.
  assign bus.req_ready = (state_q == IMEM_IDLE);
  assign bus.rsp_valid = (state_q == IMEM_RESP);
  assign bus.rsp_err   = err_q;
  assign bus.rsp_instr = err_q ? RV_NOP : rd_data;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;
  import rv_pkg::*;

  localparam int unsigned LAT_A = 2;

  logic clk;
  logic reset;
  imem_state_t state_a, state_b;

  imem_responder_if bus_a ();
  imem_responder_if bus_b ();

  imem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT_A)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_a),
    .state_dbg (state_a)
  );

  imem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_b),
    .state_dbg (state_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks (all called and returning at a negedge)
  task automatic load_both(input logic [31:0] addr, input logic [31:0] data);
    bus_a.ld_en = 1'b1; bus_a.ld_addr = addr; bus_a.ld_data = data;
    bus_b.ld_en = 1'b1; bus_b.ld_addr = addr; bus_b.ld_data = data;
    @(negedge clk);
    bus_a.ld_en = 1'b0;
    bus_b.ld_en = 1'b0;
  endtask

  // Issue one fetch on DUT A and check up to the first response cycle.
  task automatic fetch_a(input logic [31:0] addr, input logic do_ld, input logic [31:0] ld_d,
                         input logic [31:0] exp_instr, input logic exp_err, input string tag);
    check({tag, " req_ready"}, 32'(bus_a.req_ready), 32'd1);
    bus_a.req_valid = 1'b1;
    bus_a.req_addr  = addr;
    if (do_ld) begin
      bus_a.ld_en = 1'b1; bus_a.ld_addr = addr; bus_a.ld_data = ld_d;
    end
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    bus_a.ld_en     = 1'b0;
    for (int i = 0; i < LAT_A; i++) begin
      check({tag, " wait rsp_valid"}, 32'(bus_a.rsp_valid), 32'd0);
      @(negedge clk);
    end
    check({tag, " rsp_valid"}, 32'(bus_a.rsp_valid), 32'd1);
    check({tag, " rsp_instr"}, bus_a.rsp_instr, exp_instr);
    check({tag, " rsp_err"},   32'(bus_a.rsp_err), 32'(exp_err));
  endtask

  task automatic release_a(input string tag);
    bus_a.rsp_ready = 1'b1;
    @(negedge clk);
    bus_a.rsp_ready = 1'b0;
    check({tag, " idle state"}, 32'(state_a), 32'(IMEM_IDLE));
    check({tag, " rsp_valid low"}, 32'(bus_a.rsp_valid), 32'd0);
  endtask

  logic [31:0] words [4];

  initial begin
    words[0] = 32'h0050_0093;
    words[1] = 32'h0010_0113;
    words[2] = 32'hAAAA_AAAA;
    words[3] = 32'h00C5_8633;

    reset = 1'b1;
    bus_a.req_valid = 1'b0; bus_a.req_addr = 32'h0; bus_a.rsp_ready = 1'b0;
    bus_a.ld_en = 1'b0; bus_a.ld_addr = 32'h0; bus_a.ld_data = 32'h0;
    bus_b.req_valid = 1'b0; bus_b.req_addr = 32'h0; bus_b.rsp_ready = 1'b0;
    bus_b.ld_en = 1'b0; bus_b.ld_addr = 32'h0; bus_b.ld_data = 32'h0;
    @(negedge clk);
    @(negedge clk);

    // reset state
    check("reset req_ready", 32'(bus_a.req_ready), 32'd1);
    check("reset rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    check("reset rsp_instr", bus_a.rsp_instr, 32'h0);
    check("reset rsp_err", 32'(bus_a.rsp_err), 32'd0);
    check("reset state", 32'(state_a), 32'(IMEM_IDLE));
    check("reset b rsp_valid", 32'(bus_b.rsp_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) load_both(32'(i * 4), words[i]);
    // out-of-range backdoor write must not alias onto word 0
    load_both(32'h0000_1000, 32'hDEAD_BEEF);

    // 1: basic fetch, LATENCY=2
    fetch_a(32'h0, 1'b0, 32'h0, 32'h0050_0093, 1'b0, "t1");
    release_a("t1");

    // 2: response held under back-pressure
    fetch_a(32'h0, 1'b0, 32'h0, 32'h0050_0093, 1'b0, "t2");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2 hold rsp_valid", 32'(bus_a.rsp_valid), 32'd1);
      check("t2 hold rsp_instr", bus_a.rsp_instr, 32'h0050_0093);
      check("t2 hold rsp_err", 32'(bus_a.rsp_err), 32'd0);
      check("t2 hold req_ready", 32'(bus_a.req_ready), 32'd0);
    end
    release_a("t2");
    check("t2 req_ready after", 32'(bus_a.req_ready), 32'd1);

    // 3: errors
    fetch_a(32'h0000_0002, 1'b0, 32'h0, RV_NOP, 1'b1, "t3 misaligned");
    release_a("t3a");
    fetch_a(32'h0000_1000, 1'b0, 32'h0, RV_NOP, 1'b1, "t3 range");
    release_a("t3b");
    fetch_a(32'h8000_0000, 1'b0, 32'h0, RV_NOP, 1'b1, "t3 high bit");
    release_a("t3c");
    fetch_a(32'h4, 1'b0, 32'h0, 32'h0010_0113, 1'b0, "t3 recover");
    release_a("t3d");

    // 4: reset during WAIT
    bus_a.req_valid = 1'b1; bus_a.req_addr = 32'h4;
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    check("t4 in wait", 32'(state_a), 32'(IMEM_WAIT));
    reset = 1'b1;
    #1;
    check("t4 async state", 32'(state_a), 32'(IMEM_IDLE));
    check("t4 async rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    check("t4 rsp_instr cleared", bus_a.rsp_instr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4 no stale rsp", 32'(bus_a.rsp_valid), 32'd0);
    end
    fetch_a(32'h4, 1'b0, 32'h0, 32'h0010_0113, 1'b0, "t4 after");
    release_a("t4");
    fetch_a(32'h0, 1'b0, 32'h0, 32'h0050_0093, 1'b0, "t1b dropped ld");
    release_a("t1b");

    // 5: same-cycle write and accept returns the old word
    fetch_a(32'h8, 1'b1, 32'h5555_5555, 32'hAAAA_AAAA, 1'b0, "t5 old");
    release_a("t5a");
    fetch_a(32'h8, 1'b0, 32'h0, 32'h5555_5555, 1'b0, "t5 new");
    release_a("t5b");

    // 6: LATENCY=0 back-to-back with valid/ready held high
    bus_b.rsp_ready = 1'b1;
    bus_b.req_valid = 1'b1;
    bus_b.req_addr  = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6 rsp_valid", 32'(bus_b.rsp_valid), 32'd1);
      check("t6 rsp_instr", bus_b.rsp_instr, words[i]);
      check("t6 req_ready busy", 32'(bus_b.req_ready), 32'd0);
      bus_b.req_addr = 32'((i + 1) * 4);
      if (i == 3) bus_b.req_valid = 1'b0;
      @(negedge clk);
      check("t6 gap rsp_valid", 32'(bus_b.rsp_valid), 32'd0);
      check("t6 gap req_ready", 32'(bus_b.req_ready), 32'd1);
    end
    bus_b.rsp_ready = 1'b0;
    @(negedge clk);
    check("t6 idle", 32'(state_b), 32'(IMEM_IDLE));

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
